// File: rtl/gpio_seq_pkg.sv
// Shared constants for the GPIO pattern sequencer: register offsets, bit positions, FSM states.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package gpio_seq_pkg;

  // Word offsets decoded from HADDR[23:2]
  localparam logic [21:0] OFF_CTRL   = 22'd0;
  localparam logic [21:0] OFF_PERIOD = 22'd1;
  localparam logic [21:0] OFF_DATA   = 22'd2;
  localparam logic [21:0] OFF_STATUS = 22'd3;

  // CTRL bit positions
  localparam int CTRL_EN    = 0;
  localparam int CTRL_IRQEN = 1;
  localparam int CTRL_LOOP  = 2;

  // STATUS bit positions
  localparam int STAT_EMPTY     = 0;
  localparam int STAT_FULL      = 1;
  localparam int STAT_LEVEL_LSB = 4;
  localparam int STAT_LEVEL_MSB = 8;
  localparam int STAT_DONE      = 9;
  localparam int STAT_OVF       = 10;

  // Value returned for unmapped offsets
  localparam logic [31:0] RDATA_DEFAULT = 32'hDEADBEEF;

  // Width of one pattern word
  localparam int PAT_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    WAIT = 2'd2
  } seq_state_t;

endpackage

// File: rtl/gpio_seq_fifo.sv
// Synchronous pattern buffer, DEPTH x W, head word visible combinationally on pop_dat.
// Latency: push visible at head one cycle after the push edge.
// Backpressure: push while full is dropped unless a pop happens in the same cycle; pop while empty is ignored.
module gpio_seq_fifo
  import gpio_seq_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int W     = PAT_W,
  localparam int AW   = $clog2(DEPTH),
  localparam int LW   = AW + 1
) (
  input  logic          HCLK,
  input  logic          HRESETn,
  input  logic          push,
  input  logic [W-1:0]  push_dat,
  input  logic          pop,
  output logic [W-1:0]  pop_dat,
  output logic          full,
  output logic          empty,
  output logic [LW-1:0] level
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [LW-1:0] cnt;
  logic          push_ok;
  logic          pop_ok;

  assign empty   = (cnt == '0);
  assign full    = (cnt == LW'(DEPTH));
  assign level   = cnt;
  assign pop_ok  = pop & ~empty;
  // A pop frees the slot the push lands in, so full+pop still accepts.
  assign push_ok = push & (~full | pop_ok);
  assign pop_dat = mem[rd_ptr];

  // Storage array; contents are discarded by resetting the pointers only.
  always_ff @(posedge HCLK) begin
    if (push_ok) mem[wr_ptr] <= push_dat;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   cnt <= cnt + LW'(1);
        2'b01:   cnt <= cnt - LW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/gpio_seq.sv
// AHB-lite GPIO pattern sequencer: plays buffered 16-bit words onto SEQ_DOUT every PERIOD+1 cycles. Loop mode via GPIO_SEQ_LOOP_EN.
// Latency: first pattern two edges after the EN-setting write's data phase; zero-wait-state bus.
// Backpressure: none on the bus (HREADYOUT=1); DATA pushes into a full buffer are dropped and flag OVF.
module gpio_seq
  import gpio_seq_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int PW         = 16
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HSEL,
  input  logic [23:2] HADDR,
  input  logic        HREADY,
  input  logic        HWRITE,
  input  logic [1:0]  HTRANS,
  input  logic [2:0]  HSIZE,
  input  logic [31:0] HWDATA,
  output logic [31:0] HRDATA,
  output logic        HREADYOUT,
  output logic [1:0]  HRESP,
  output logic [15:0] SEQ_DOUT,
  output logic        SEQ_ACTIVE,
  output logic        IRQ
);

  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  // Bus pipeline
  logic        acc_q;
  logic        write_q;
  logic [23:2] addr_q;
  logic        wr_vld;
  logic        rd_vld;
  logic        ctrl_wr;
  logic        period_wr;
  logic        data_wr;
  logic        status_wr;

  // Registers
  logic          en_q;
  logic          irqen_q;
  logic          loop_q;
  logic [PW-1:0] period_q;
  logic          done_q;
  logic          ovf_q;
  logic          irq_q;
  logic [15:0]   dout_q;

  // Sequencer
  seq_state_t    state_q;
  seq_state_t    state_nxt;
  logic [PW-1:0] cnt_q;
  logic [PW-1:0] cnt_nxt;
  logic          done_set;
  logic          go_idle;
  logic          more_after;

  // Pattern buffer
  logic          fifo_push;
  logic [15:0]   fifo_push_dat;
  logic          fifo_pop;
  logic [15:0]   fifo_head;
  logic          fifo_full;
  logic          fifo_empty;
  logic [LW-1:0] fifo_level;
  logic          loop_push;
  logic          ovf_set;

  logic          unused_bits;
  assign unused_bits = ^{HSIZE, HTRANS[0], HWDATA[31:16]};

  assign HREADYOUT  = 1'b1;
  assign HRESP      = 2'b00;
  assign SEQ_DOUT   = dout_q;
  assign SEQ_ACTIVE = en_q;
  assign IRQ        = irq_q;

  // Capture the address phase; only non-idle, selected transfers become accesses.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      acc_q   <= 1'b0;
      write_q <= 1'b0;
      addr_q  <= '0;
    end else if (HREADY) begin
      acc_q   <= HSEL & HTRANS[1];
      write_q <= HWRITE;
      addr_q  <= HADDR;
    end
  end

  assign wr_vld    = acc_q & write_q;
  assign rd_vld    = acc_q & ~write_q;
  assign ctrl_wr   = wr_vld & (addr_q == OFF_CTRL);
  assign period_wr = wr_vld & (addr_q == OFF_PERIOD);
  assign data_wr   = wr_vld & (addr_q == OFF_DATA);
  assign status_wr = wr_vld & (addr_q == OFF_STATUS);

  // A write clearing EN takes the FSM to IDLE on the same edge it lands.
  assign go_idle = ~en_q | (ctrl_wr & ~HWDATA[CTRL_EN]);

  // LOAD only occurs with a non-empty buffer; the empty term keeps the pop safe regardless.
  assign fifo_pop      = (state_q == LOAD) & ~go_idle & ~fifo_empty;
  assign loop_push     = fifo_pop & loop_q;
  assign fifo_push     = data_wr | loop_push;
  assign fifo_push_dat = loop_push ? fifo_head : HWDATA[15:0];
  // A bus push is lost when the buffer is full without a pop, or when a loop re-push owns the port.
  assign ovf_set       = data_wr & (loop_push | (fifo_full & ~fifo_pop));

  // Whether the buffer still holds a word after the current LOAD pop.
  assign more_after = (fifo_level != LW'(1)) | loop_q | data_wr;

  gpio_seq_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (16)
  ) u_fifo (
    .HCLK     (HCLK),
    .HRESETn  (HRESETn),
    .push     (fifo_push),
    .push_dat (fifo_push_dat),
    .pop      (fifo_pop),
    .pop_dat  (fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .level    (fifo_level)
  );

  // CTRL and PERIOD registers.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      en_q     <= 1'b0;
      irqen_q  <= 1'b0;
      period_q <= '0;
    end else begin
      if (ctrl_wr) begin
        en_q    <= HWDATA[CTRL_EN];
        irqen_q <= HWDATA[CTRL_IRQEN];
      end
      if (period_wr) period_q <= HWDATA[PW-1:0];
    end
  end

`ifdef GPIO_SEQ_LOOP_EN
  // Loop-mode bit: when set each popped word is recycled to the tail.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) loop_q <= 1'b0;
    else if (ctrl_wr) loop_q <= HWDATA[CTRL_LOOP];
  end
`else
  assign loop_q = 1'b0;
`endif

  // Sticky DONE/OVF flags; a set in the same cycle as a W1C wins.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      done_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      if (done_set) done_q <= 1'b1;
      else if (status_wr && HWDATA[STAT_DONE]) done_q <= 1'b0;
      if (ovf_set) ovf_q <= 1'b1;
      else if (status_wr && HWDATA[STAT_OVF]) ovf_q <= 1'b0;
    end
  end

  // Registered level interrupt.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) irq_q <= 1'b0;
    else irq_q <= irqen_q & (done_q | ovf_q);
  end

  // Sequencer state, interval counter and output pattern.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dout_q  <= '0;
    end else begin
      state_q <= state_nxt;
      cnt_q   <= cnt_nxt;
      if (fifo_pop) dout_q <= fifo_head;
    end
  end

  // Next state: LOAD..LOAD spacing is one LOAD cycle plus PERIOD WAIT cycles.
  always_comb begin
    state_nxt = state_q;
    cnt_nxt   = cnt_q;
    done_set  = 1'b0;
    if (go_idle) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!fifo_empty) state_nxt = LOAD;
        end
        LOAD: begin
          cnt_nxt = period_q;
          if (period_q == '0) begin
            if (more_after) begin
              state_nxt = LOAD;
            end else begin
              state_nxt = IDLE;
              done_set  = 1'b1;
            end
          end else begin
            state_nxt = WAIT;
          end
        end
        WAIT: begin
          if (cnt_q <= PW'(1)) begin
            cnt_nxt = '0;
            if (!fifo_empty) begin
              state_nxt = LOAD;
            end else begin
              state_nxt = IDLE;
              done_set  = 1'b1;
            end
          end else begin
            cnt_nxt = cnt_q - PW'(1);
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Data-phase read mux; unused bits read 0, unmapped offsets read the default word.
  always_comb begin
    HRDATA = '0;
    if (rd_vld) begin
      case (addr_q)
        OFF_CTRL: begin
          HRDATA[CTRL_EN]    = en_q;
          HRDATA[CTRL_IRQEN] = irqen_q;
          HRDATA[CTRL_LOOP]  = loop_q;
        end
        OFF_PERIOD: HRDATA[PW-1:0] = period_q;
        OFF_DATA:   HRDATA[15:0]   = dout_q;
        OFF_STATUS: begin
          HRDATA[STAT_EMPTY] = fifo_empty;
          HRDATA[STAT_FULL]  = fifo_full;
          HRDATA[STAT_LEVEL_MSB:STAT_LEVEL_LSB] = 5'(fifo_level);
          HRDATA[STAT_DONE]  = done_q;
          HRDATA[STAT_OVF]   = ovf_q;
        end
        default: HRDATA = RDATA_DEFAULT;
      endcase
    end
  end

endmodule

// File: doc/gpio_seq.md
GPIO_SEQ -- requirements
Module: gpio_seq

Interface
REQ-001 The block SHALL have parameter FIFO_DEPTH, default 8, power-of-two pattern-buffer depth (2..16).
REQ-002 The block SHALL have parameter PW, default 16, width of the PERIOD register and interval counter.
REQ-003 The block SHALL use clock HCLK and reset HRESETn, asynchronous, active-low.
REQ-004 Ports SHALL be, clock and reset first, as listed:
- HCLK  in  1  clock
- HRESETn  in  1  async active-low reset
- HSEL  in  1  slave select
- HADDR  in  [23:2]  word address
- HREADY  in  1  bus ready
- HWRITE  in  1  write
- HTRANS  in  2  transfer type
- HSIZE  in  3  transfer size, word only
- HWDATA  in  32  write data
- HRDATA  out  32  read data
- HREADYOUT  out  1  tied 1
- HRESP  out  2  tied 0
- SEQ_DOUT  out  16  pattern driven onto the GPIO output mux
- SEQ_ACTIVE  out  1  selects SEQ_DOUT over software WGPIODOUT
- IRQ  out  1  level interrupt

Function
REQ-005 Address phase SHALL be registered when HSEL&HREADY; access SHALL occur in the data phase only if HTRANS[1] was set; zero wait states.
REQ-006 Register map by HADDR[23:2]:
- 0 CTRL: [0] EN, [1] IRQEN, [2] LOOP
- 1 PERIOD: [PW-1:0]
- 2 DATA: write pushes HWDATA[15:0]; read returns SEQ_DOUT
- 3 STATUS: [0] EMPTY, [1] FULL, [8:4] LEVEL, [9] DONE (W1C), [10] OVF (W1C)
- any other offset SHALL read 32'hDEADBEEF; unused bits read 0
REQ-007 FSM states SHALL be IDLE, LOAD, WAIT.
- IDLE->LOAD when EN=1 and not EMPTY.
- LOAD pops the FIFO head into SEQ_DOUT, loads the counter with PERIOD, then goes to WAIT.
- WAIT decrements the counter; at 0 it goes to LOAD if not EMPTY, else sets DONE and goes to IDLE.
REQ-008 Consecutive pattern updates SHALL be exactly PERIOD+1 HCLK cycles apart; PERIOD=0 SHALL update every cycle.
REQ-009 The first pattern SHALL appear on SEQ_DOUT 2 cycles after the data phase of the CTRL write setting EN.
REQ-010 SEQ_ACTIVE SHALL equal the CTRL.EN register; SEQ_DOUT SHALL hold its last value when IDLE or EN=0.
REQ-011 Clearing EN SHALL force IDLE on the next edge, clear the counter, and retain FIFO contents and SEQ_DOUT.
REQ-012 A push when FULL with no simultaneous pop SHALL be dropped and set OVF; a simultaneous push and pop when FULL SHALL accept the push.
REQ-013 A pop when EMPTY SHALL be impossible by construction; read and write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-014 IRQ SHALL equal IRQEN & (DONE | OVF), registered.
REQ-015 PERIOD writes during WAIT SHALL take effect at the next reload only.

Reset
REQ-016 Reset SHALL clear SEQ_DOUT, SEQ_ACTIVE, IRQ, CTRL, PERIOD, DONE, OVF, the FIFO pointers and the counter, and SHALL force IDLE.
REQ-017 Reset asserted mid-sequence SHALL discard FIFO contents; outputs SHALL be 0 while reset is asserted.

Configuration
REQ-018 With macro GPIO_SEQ_LOOP_EN defined and CTRL.LOOP=1, each LOAD SHALL re-push the popped word to the tail, so the sequence repeats indefinitely and DONE never sets.
REQ-019 Without GPIO_SEQ_LOOP_EN, CTRL[2] SHALL read 0 and ignore writes.

Structure
REQ-020 A shared package gpio_seq_pkg SHALL hold the register offset constants, the STATUS/CTRL bit positions, the FSM state enum and the 32'hDEADBEEF default read value.
REQ-021 The pattern buffer SHALL be a sub-module gpio_seq_fifo (sync, FIFO_DEPTH x 16, push/pop/full/empty/level).

Verification
REQ-022 Bench scenarios:
- Push 0x0001, 0x0002, 0x0004; PERIOD=3; EN=1 -> SEQ_DOUT 1,2,4 at 4-cycle spacing, then DONE=1, IRQ=0 with IRQEN=0.
- Same as above with IRQEN=1 -> IRQ rises the cycle after DONE sets; writing STATUS=0x200 clears DONE and IRQ.
- Push 9 words with FIFO_DEPTH=8 -> LEVEL=8, FULL=1, OVF=1; the 9th word is never output.
- Clear EN after the 2nd pattern -> SEQ_DOUT holds 0x0002; set EN again -> 0x0004 follows.
- GPIO_SEQ_LOOP_EN defined, LOOP=1, push 0xA, 0xB, PERIOD=0 -> SEQ_DOUT A,B,A,B every cycle; LEVEL stays 2.
- Read offset 5 -> 0xDEADBEEF; assert reset mid-WAIT -> all outputs 0, EMPTY=1.
